// File: rtl/uart_pkg.sv
// Purpose : shared types and constants for the UART transmit feeder.
// Latency : n/a (types only).
// Backpressure: n/a.
// Contents: uart_byte_t, UART_CR / UART_LF, feeder FSM state enum.
// Config  : UART_TX_FEEDER_CRLF_EN adds the ST_SEND_LF state.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  localparam uart_byte_t UART_CR = 8'h0D;
  localparam uart_byte_t UART_LF = 8'h0A;

`ifdef UART_TX_FEEDER_CRLF_EN
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_SEND_LF   = 2'd3
  } feeder_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2
  } feeder_state_t;
`endif

endpackage

// File: rtl/uart_byte_fifo.sv
// Purpose : synchronous byte FIFO, first-word-fall-through read port.
// Latency : write visible in count/empty one cycle after the write edge.
// Backpressure: writes while full are dropped; reads while empty are ignored.
// Ports   : clk, rst (sync, active-high), wr_en/wr_data push, rd_en pops the
//           byte currently on rd_data, full/empty/count occupancy status.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  uart_byte_t               wr_data,
  input  logic                     rd_en,
  output uart_byte_t               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  uart_byte_t  mem [DEPTH];
  logic        do_wr;
  logic        do_rd;

  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  // full is the pre-edge value, so a write while full is dropped even if a
  // pop happens on the same edge.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Purpose : buffers bytes and paces them into uart_tx_ctrl via ready/send.
// Latency : write at edge N -> pop at N+1 -> tx_send high N+2..N+3 (idle tx).
// Backpressure: producer must watch full; writes while full are dropped.
// Ports   : clk, rst (sync, active-high); wr_en/wr_data producer write port;
//           full/empty/count FIFO status; tx_ready from uart_tx_ctrl.ready;
//           tx_send/tx_data to uart_tx_ctrl.send/.data (registered).
// Config  : define UART_TX_FEEDER_CRLF_EN to expand each LF into CR then LF.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     tx_ready,
  output logic                     tx_send,
  output logic [7:0]               tx_data
);

  feeder_state_t state;
  uart_byte_t    head;
  logic          pop;

  // Pop only when the byte can be handed over right away, so nothing is
  // ever removed from the FIFO without being sent.
  assign pop = (state == ST_IDLE) && !empty && tx_ready;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

`ifdef UART_TX_FEEDER_CRLF_EN
  // Set while the CR of an expanded LF is in flight; the LF itself has
  // already left the FIFO and is regenerated from the constant.
  logic lf_pending;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx_send <= 1'b0;
      tx_data <= 8'h00;
`ifdef UART_TX_FEEDER_CRLF_EN
      lf_pending <= 1'b0;
`endif
    end else begin
      tx_send <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
`ifdef UART_TX_FEEDER_CRLF_EN
            if (head == UART_LF) begin
              tx_data    <= UART_CR;
              lf_pending <= 1'b1;
            end else begin
              tx_data <= head;
            end
`else
            tx_data <= head;
`endif
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          tx_send <= 1'b1;
          state   <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // ready dropping is the transmitter's acknowledgement of the byte.
          if (!tx_ready) begin
`ifdef UART_TX_FEEDER_CRLF_EN
            state <= lf_pending ? ST_SEND_LF : ST_IDLE;
`else
            state <= ST_IDLE;
`endif
          end
        end
`ifdef UART_TX_FEEDER_CRLF_EN
        ST_SEND_LF: begin
          if (tx_ready) begin
            tx_data    <= UART_LF;
            lf_pending <= 1'b0;
            state      <= ST_SEND;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Purpose : scoreboard bench for uart_tx_feeder with a behavioural transmitter.
// Latency : n/a.
// Backpressure: transmitter model holds ready low for BUSY cycles per byte.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int BUSY  = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       tx_ready;
  logic       tx_send;
  logic [7:0] tx_data;

  logic       hold = 1'b0;
  int         busy_cnt = 0;

  int         checks = 0;
  int         errors = 0;
  int         sent_cnt = 0;
  bit         wrap_mon = 1'b0;
  bit         prev_send = 1'b0;
  logic [7:0] exp_q[$];

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .tx_ready (tx_ready),
    .tx_send  (tx_send),
    .tx_data  (tx_data)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for BUSY cycles after each send pulse.
  assign tx_ready = !hold && (busy_cnt == 0);
  always @(posedge clk) begin
    if (tx_send) busy_cnt <= BUSY;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every send pulse is compared with the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && tx_send) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_send: got %0h, expected no send", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL send_data: got %0h, expected %0h", tx_data, e);
        end
      end
      checks++;
      if (!tx_ready || prev_send) begin
        errors++;
        $display("FAIL send_protocol: ready=%0b prev_send=%0b, expected ready=1 prev_send=0",
                 tx_ready, prev_send);
      end
      sent_cnt++;
    end
    prev_send = tx_send;
    if (wrap_mon) begin
      checks++;
      if (count > DEPTH || empty != (count == 0) || full != (count == DEPTH)) begin
        errors++;
        $display("FAIL wrap_flags: count=%0d empty=%0b full=%0b, expected consistent", count, empty, full);
      end
    end
  end

  task automatic push_exp(input logic [7:0] d);
`ifdef UART_TX_FEEDER_CRLF_EN
    if (d == UART_LF) exp_q.push_back(UART_CR);
`endif
    exp_q.push_back(d);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) push_exp(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !empty || !tx_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes outstanding, expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    int peak;
    int n;
    logic [7:0] burst [9];
    burst = '{8'hA5, 8'h00, 8'hFF, 8'h5A, 8'h01, 8'h88, 8'h41, 8'h41, 8'h42};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte latency
    wr_en = 1'b1; wr_data = 8'hA5; push_exp(8'hA5);
    @(negedge clk);
    wr_en = 1'b0;
    chk("single_empty_after_N", empty, 0);
    chk("single_count_after_N", count, 1);
    @(negedge clk);
    chk("single_send_N1", tx_send, 0);
    @(negedge clk);
    chk("single_send_N2", tx_send, 1);
    chk("single_data_N2", tx_data, 8'hA5);
    @(negedge clk);
    chk("single_send_N3", tx_send, 0);
    wait_drain("single");

    // Burst of nine bytes on consecutive cycles
    peak = 0;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = burst[i]; push_exp(burst[i]);
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
    end
    wr_en = 1'b0;
    chk("burst_peak_8_or_9", int'(peak >= 8 && peak <= 9), 1);
    wait_drain("burst");
    chk("burst_end_count", count, 0);

    // Overflow: transmitter held busy, 20 writes into 16 slots
    hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      write_byte(8'(i), i < DEPTH);
      if (i == DEPTH - 1) begin
        chk("ovf_full_at_16", full, 1);
        chk("ovf_count_at_16", count, 16);
      end
    end
    chk("ovf_full_after_20", full, 1);
    chk("ovf_count_after_20", count, 16);
    hold = 1'b0;
    wait_drain("ovf");
    chk("ovf_empty_end", empty, 1);

    // Wrap-around: 3*DEPTH bytes, producer polls full
    wrap_mon = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      n = 0;
      while (full && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) chk("wrap_full_stuck", 1, 0);
      write_byte(8'(i * 37 + 11), 1'b1);
      repeat (i % 4) @(negedge clk);
    end
    wait_drain("wrap");
    wrap_mon = 1'b0;

    // Reset after the second send of a five-byte burst
    sent_cnt = 0;
    for (int i = 0; i < 5; i++) write_byte(8'h31 + 8'(i), 1'b1);
    n = 0;
    while (sent_cnt < 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_reach_two", int'(n < 1000), 1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_count", count, 0);
    chk("rstmid_empty", empty, 1);
    repeat (200) @(negedge clk);
    chk("rstmid_no_more_sends", sent_cnt, 2);
    write_byte(8'h42, 1'b1);
    wait_drain("rstmid");
    chk("rstmid_after_send", sent_cnt, 3);

    // LF handling
    sent_cnt = 0;
    write_byte(8'h41, 1'b1);
    write_byte(8'h0A, 1'b1);
    wait_drain("crlf");
`ifdef UART_TX_FEEDER_CRLF_EN
    chk("crlf_send_count", sent_cnt, 3);
`else
    chk("crlf_send_count", sent_cnt, 2);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and pacing stage sitting directly upstream of `uart_tx_ctrl`. Producers write bytes at clock rate into an internal FIFO. The feeder drains the FIFO one byte at a time into the transmitter using its `ready`/`send` handshake, so callers never have to poll transmitter status themselves. This is the transmit-side counterpart of the receive FIFO behind `uart_rx_ctrl`.

## Interface
- `DEPTH`, 16, FIFO depth in bytes; power of two, 2..256.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `wr_en`  in  1  write strobe; `wr_data` is pushed on this edge unless `full`.
- `wr_data`  in  8  byte to queue.
- `full`  out  1  FIFO holds DEPTH bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  log2(DEPTH)+1  current occupancy.
- `tx_ready`  in  1  connects to `uart_tx_ctrl.ready`; high when the transmitter is idle.
- `tx_send`  out  1  connects to `uart_tx_ctrl.send`; one-cycle pulse.
- `tx_data`  out  8  connects to `uart_tx_ctrl.data`; valid while `tx_send` is high, and held afterwards.

## Operation
- **FIFO:** circular buffer with read/write pointers of log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - `full`: pointer addresses are equal and the MSBs differ.
  - `empty`: pointers are fully equal.
- **Write while full:** the byte is dropped and no state changes. `full` is evaluated before any same-cycle pop, so a write and a pop on the same edge while full still drops the write.
- **Simultaneous write and pop while not full:** both take effect; `count` is unchanged.
- **State machine** (the state type lives in the package):
  - IDLE: if `!empty && tx_ready`, pop the head byte into `tx_data`, then go to SEND.
  - SEND: `tx_send`=1 for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: stay until `tx_ready`=0 (transmitter accepted the byte), then go to IDLE.
  - IDLE's `tx_ready` requirement ensures the next byte waits for the stop bit to complete.
- No byte is popped unless it will be sent; bytes are never reordered or duplicated.
- **Reset values:** `tx_send`=0, `tx_data`=8'h00, `count`=0, `empty`=1, `full`=0, state IDLE, pointers 0.
- **Reset mid-operation:** FIFO contents are discarded and the FSM returns to IDLE. A frame already handed to `uart_tx_ctrl` completes on the line independently.

## Timing
- `count`, `full` and `empty` are registered and reflect a write one cycle after the `wr_en` edge.
- **Latency** (FIFO empty, `tx_ready` high):
  - write at edge N;
  - `empty`=0 after edge N;
  - pop at edge N+1;
  - `tx_send` high from edge N+2 to edge N+3.
- **Back-to-back bytes:** the next `tx_send` occurs no earlier than 1 cycle after `tx_ready` returns high.
- **Throughput:** one byte per UART frame time (10 bit periods at BAUD).
- The write port is never backpressured beyond `full`. Producers must check `full` themselves.

## Configuration
- Macro: `UART_TX_FEEDER_CRLF_EN`.
- **Defined:** when the popped byte is 8'h0A (LF), the feeder first sends 8'h0D (CR), then 8'h0A.
  - This adds state SEND_LF, reached from WAIT_BUSY after the CR is accepted.
  - SEND_LF waits for `tx_ready` high, then pulses `tx_send` with 8'h0A.
  - The LF occupies one FIFO slot only.
  - A stored 8'h0D is sent unchanged (no CR doubling check).
- **Undefined:** all bytes are sent verbatim; SEND_LF does not exist.

## Structure
- **Package `uart_pkg`:**
  - `uart_byte_t` (8-bit typedef);
  - constants `UART_CR`=8'h0D and `UART_LF`=8'h0A;
  - the feeder FSM state enum.
- **Sub-module `uart_byte_fifo`:**
  - the synchronous FIFO, parameterised by DEPTH;
  - ports `clk`, `rst`, `wr_en`, `wr_data`, `rd_en`, `rd_data` (first-word-fall-through), `full`, `empty`, `count`.
- **Top level:** holds the FSM and the CRLF logic only.

## Test plan
- **Single byte:** reset, `tx_ready`=1; write 8'hA5 → `tx_send` pulses 2 cycles after the write edge with `tx_data`=8'hA5; `uart_tx_ctrl` serial output decodes to 8'hA5.
- **Burst:** write 8'hA5, 00, FF, 5A, 01, 88, 41, 41, 42 on consecutive cycles → nine `tx_send` pulses, in order, each only after `tx_ready` has returned high; `count` peaks at 8 or 9 and ends at 0.
- **Overflow:** DEPTH=16, `tx_ready` held 0; write 20 bytes 8'h00..8'h13 → `full`=1 after 16 writes and `count`=16; release `tx_ready` → exactly 8'h00..8'h0F are sent, and 8'h10..8'h13 are never sent.
- **Wrap-around:** perform 3×DEPTH write/drain cycles with interleaved simultaneous write+pop → output order matches input, `empty`/`full` are correct at every step, and `count` never exceeds DEPTH.
- **Reset mid-burst:** queue 5 bytes, assert `rst` for 1 cycle after the 2nd `tx_send` → no further `tx_send`; `count`=0, `empty`=1; a later write of 8'h42 is sent normally.
- **CRLF (macro defined):** write 8'h41, 8'h0A → `tx_send` sequence 8'h41, 8'h0D, 8'h0A. With the macro undefined, the sequence is 8'h41, 8'h0A.
